// File: rtl/jtag_bus_bridge.sv
// Purpose: bridges TAP Update-DR commands (addr / write / read / status) onto a simple req/ack bus.
// Latency: SYNC_STAGES clk from update_dr rise to command; bus_req registered, drops the cycle after bus_ack.
// Backpressure: one transaction in flight; commands arriving while busy are dropped and flagged as overrun.
module jtag_bus_bridge #(
  parameter int IR_WIDTH    = 5,
  parameter int DR_WIDTH    = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter logic [IR_WIDTH-1:0] IR_ADDR   = 5'h08,
  parameter logic [IR_WIDTH-1:0] IR_WRITE  = 5'h09,
  parameter logic [IR_WIDTH-1:0] IR_READ   = 5'h0A,
  parameter logic [IR_WIDTH-1:0] IR_STATUS = 5'h0B
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IR_WIDTH-1:0]   instruction,
  input  logic [DR_WIDTH-1:0]   dr_out,
  input  logic                  update_dr,
  output logic [DR_WIDTH-1:0]   dr_in,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DR_WIDTH-1:0]   bus_wdata,
  input  logic                  bus_ack,
  input  logic [DR_WIDTH-1:0]   bus_rdata,
  output logic                  busy
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DR_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sample_vld_q;
  logic                   evt_prev_q;
  logic                   evt_armed_q;
  logic                   upd_evt;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DR_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DR_WIDTH-1:0]   rdata_q, rdata_d;
  logic                  ovr_q, ovr_d;
  logic                  tmo_q, tmo_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Synchronise update_dr and track whether each stage holds a real sample since reset.
  // The detector only arms once a genuine low level has reached the last stage, so a
  // strobe already high across reset release cannot masquerade as a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      sample_vld_q <= '0;
      evt_prev_q   <= 1'b0;
      evt_armed_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], update_dr};
      sample_vld_q <= {sample_vld_q[SYNC_STAGES-2:0], 1'b1};
      evt_prev_q   <= sync_q[SYNC_STAGES-1];
      if (sample_vld_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1]) begin
        evt_armed_q <= 1'b1;
      end
    end
  end

  assign upd_evt = sync_q[SYNC_STAGES-1] & ~evt_prev_q & evt_armed_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and register-update decode: commands in IDLE, ack/timeout/overrun while busy.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ovr_d   = ovr_q;
    tmo_d   = tmo_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (upd_evt) begin
          if (instruction == IR_ADDR) begin
            addr_d = dr_out[ADDR_WIDTH-1:0];
          end else if (instruction == IR_WRITE) begin
            wdata_d = dr_out;
            state_d = WR;
          end else if (instruction == IR_READ) begin
            state_d = RD;
          end else if (instruction == IR_STATUS && dr_out[0]) begin
            ovr_d = 1'b0;
            tmo_d = 1'b0;
          end
        end
      end
      WR, RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (upd_evt) begin
          ovr_d = 1'b1;
        end
        // Ack wins over a timeout expiring in the same cycle.
        if (bus_ack) begin
          if (state_q == RD) begin
            rdata_d = bus_rdata;
          end
          addr_d  = addr_q + ADDR_STEP;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers; bus outputs are registered from the next-state values so they
  // assert on state entry and stay stable for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ovr_q     <= 1'b0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      ovr_q     <= ovr_d;
      tmo_q     <= tmo_d;
      cnt_q     <= cnt_d;
      bus_req   <= (state_d != IDLE);
      bus_we    <= (state_d == WR);
      bus_addr  <= addr_d;
      bus_wdata <= wdata_d;
    end
  end

  assign busy = (state_q != IDLE);

  // Capture data for the TAP, selected by the current instruction.
  always_comb begin
    dr_in = '0;
    if (instruction == IR_STATUS) begin
      dr_in[2:0] = {ovr_q, tmo_q, busy};
    end else if (instruction == IR_ADDR) begin
      dr_in[ADDR_WIDTH-1:0] = addr_q;
    end else begin
      dr_in = rdata_q;
    end
  end

endmodule

// File: doc/jtag_bus_bridge.md
JTAG_BUS_BRIDGE -- requirements
Module: jtag_bus_bridge

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 5, meaning instruction width from the TAP.
REQ-002 SHALL have parameter DR_WIDTH, default 32, meaning data register and bus data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, meaning bus address width.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, meaning update_dr synchronizer depth (minimum 2).
REQ-005 SHALL have parameter TIMEOUT, default 255, meaning maximum clk cycles to wait for bus_ack.
REQ-006 SHALL have parameters IR_ADDR=5'h08, IR_WRITE=5'h09, IR_READ=5'h0A and IR_STATUS=5'h0B, meaning the decoded opcodes.
REQ-007 SHALL have the following ports, clock and reset first:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- instruction  input  IR_WIDTH  TAP instruction; quasi-static.
- dr_out  input  DR_WIDTH  TAP shifted data; quasi-static.
- update_dr  input  1  TAP Update-DR strobe; TCK domain, treated as asynchronous.
- dr_in  output  DR_WIDTH  capture data returned to the TAP.
- bus_req  output  1  bus request.
- bus_we  output  1  1 = write.
- bus_addr  output  ADDR_WIDTH  bus address.
- bus_wdata  output  DR_WIDTH  write data.
- bus_ack  input  1  single-cycle completion.
- bus_rdata  input  DR_WIDTH  read data, valid with bus_ack.
- busy  output  1  transaction in progress.

Function
REQ-008 SHALL pass update_dr through SYNC_STAGES flops, then a rising-edge detector, producing a one-clk pulse upd_evt.
REQ-009 SHALL assert upd_evt for exactly one cycle per update_dr rising edge, however long update_dr stays high.
REQ-010 SHALL, if update_dr is first sampled high at edge N, make upd_evt take effect at edge N+SYNC_STAGES; dr_out and instruction SHALL be sampled at that edge.
REQ-011 SHALL implement the FSM states IDLE, WR, RD and STATUS-free decode; all opcode handling SHALL occur in IDLE on upd_evt.
REQ-012 SHALL, on IR_ADDR, load addr_reg <= dr_out[ADDR_WIDTH-1:0] and stay in IDLE.
REQ-013 SHALL, on IR_WRITE, load wdata_reg <= dr_out and go to WR.
REQ-014 SHALL, on IR_READ, go to RD and ignore dr_out.
REQ-015 SHALL, on IR_STATUS with dr_out[0]=1, clear the overrun and timeout sticky flags.
REQ-016 SHALL ignore any other opcode.
REQ-017 SHALL, in WR/RD, hold bus_req=1, bus_we=(state==WR), bus_addr=addr_reg and bus_wdata=wdata_reg, all registered and stable until exit.
REQ-018 SHALL, on bus_ack in RD, load rdata_reg <= bus_rdata.
REQ-019 SHALL, on bus_ack in WR or RD, increment addr_reg by DR_WIDTH/8 modulo 2^ADDR_WIDTH (0xFFFC+4 -> 0x0000) and return to IDLE; bus_req SHALL be 0 the following cycle.
REQ-020 SHALL count cycles in WR/RD with a counter that resets on state entry; when it reaches TIMEOUT without bus_ack, the FSM SHALL set the timeout flag, return to IDLE, and leave addr_reg and rdata_reg unchanged.
REQ-021 SHALL give bus_ack priority over timeout when both occur in the same cycle.
REQ-022 SHALL, on upd_evt while in WR/RD, drop the event, set the overrun flag and leave the transaction unaffected.
REQ-023 SHALL ignore bus_ack while in IDLE.
REQ-024 SHALL drive busy=1 exactly when the state is WR or RD.
REQ-025 SHALL drive dr_in combinationally from registers: when instruction==IR_STATUS, {zeros, overrun, timeout, busy} in bits [2:0]; when IR_ADDR, zero-extended addr_reg; otherwise rdata_reg.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, addr_reg=0, wdata_reg=0, rdata_reg=0, flags=0, busy=0, dr_in=0 and all sync/edge flops=0.
REQ-027 SHALL, if reset asserts mid-transaction, abandon the transaction with no further bus_req; after release, an update_dr already high SHALL NOT generate upd_evt until it falls and rises again.

Verification
REQ-028 The bench SHALL cover: IR_ADDR dr_out=0x1000, then IR_WRITE 0xDEADBEEF with ack after 3 cycles -> one bus_req write at 0x1000 with wdata DEADBEEF; addr_reg=0x1004; busy low after ack.
REQ-029 The bench SHALL cover: IR_READ at addr 0x1004 with bus_rdata=0x12345678 -> dr_in=0x12345678 under a non-status IR; addr_reg=0x1008.
REQ-030 The bench SHALL cover: a write with no bus_ack -> bus_req drops after exactly 255 cycles in WR; STATUS dr_in[1]=1; addr_reg unchanged.
REQ-031 The bench SHALL cover: a second update_dr pulse during RD -> transaction completes normally; dr_in[2]=1 under IR_STATUS; IR_STATUS with dr_out=1 clears it to 0.
REQ-032 The bench SHALL cover: addr_reg=0xFFFC write acked -> addr_reg=0x0000; and update_dr held high for 20 cycles -> exactly one transaction.
REQ-033 The bench SHALL cover: rst_n pulsed low during RD -> bus_req=0 immediately, all outputs 0, and no event until a fresh update_dr rising edge.
